// File: rtl/multi_lane_spi_pkg.sv
// multi_lane_spi shared types and helpers.
// FSM states, lane-mode encodings and beat arithmetic.
package multi_lane_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_UPDATE
    } state_t;

    localparam logic [1:0] LANES_1   = 2'b00;
    localparam logic [1:0] LANES_2   = 2'b01;
    localparam logic [1:0] LANES_4   = 2'b10;
    localparam logic [1:0] LANES_RSV = 2'b11;

    function automatic int lanes_of(input logic [1:0] mode);
        int l;
        l = 1;
        unique case (1'b1)
            (mode == LANES_2): l = 2;
            (mode == LANES_4): l = 4;
            default:           l = 1;
        endcase
        return l;
    endfunction

    function automatic int beats(input int n, input int l);
        return (n + l - 1) / l;
    endfunction

endpackage

// File: rtl/multi_lane_spi_if.sv
// multi_lane_spi request and DDS pin bundle.
// master = sequencer side, slave = the serialiser.
interface multi_lane_spi_if #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = $clog2(DATA_W + 1)
);
    logic              i_start;
    logic [1:0]        i_lanes_mode;
    logic              i_msb_first;
    logic [LEN_W-1:0]  i_nbits;
    logic              i_io_update_req;
    logic [DATA_W-1:0] i_data_in;
    logic              o_busy;
    logic              o_done;
    logic              o_cs_n;
    logic              o_sclk;
    logic [3:0]        o_sdio;
    logic              o_io_update;

    modport master (
        output i_start, i_lanes_mode, i_msb_first,
        output i_nbits, i_io_update_req, i_data_in,
        input  o_busy, o_done, o_cs_n, o_sclk,
        input  o_sdio, o_io_update
    );

    modport slave (
        input  i_start, i_lanes_mode, i_msb_first,
        input  i_nbits, i_io_update_req, i_data_in,
        output o_busy, o_done, o_cs_n, o_sclk,
        output o_sdio, o_io_update
    );
endinterface

// File: rtl/multi_lane_spi_tick.sv
// spi_tick_gen: half-period counter for SCLK pacing.
// Emits o_tick on the last of every DIV enabled cycles.
module spi_tick_gen #(
    parameter int DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == CW'(DIV - 1));

    // count enabled cycles, wrap at DIV-1
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/multi_lane_spi.sv
// multi_lane_spi: 1/2/4-lane serial master for the AD9958.
// Window is pre-aligned at latch so each beat reads a fixed slice.
module multi_lane_spi
    import multi_lane_spi_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DIV    = 2,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    multi_lane_spi_if.slave    bus
);
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_win;
    logic [LEN_W-1:0]  r_beat;
    logic [LEN_W-1:0]  r_nb;
    logic [2:0]        r_lanes;
    logic              r_phase;
    logic              r_msb;
    logic              r_upd;
    logic              r_done;

    logic              w_accept;
    logic              w_tick;
    logic              w_busy;
    logic              w_last;
    logic              w_finish;
    logic [2:0]        w_lanes;
    logic [LEN_W-1:0]  w_nb;
    logic [DATA_W-1:0] w_win;
    logic [3:0]        w_beat;
    logic              w_cs_n;
    logic              w_sclk;
    logic [3:0]        w_sdio;
    logic              w_iou;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_accept = (r_state == ST_IDLE) && bus.i_start
                   && (bus.i_lanes_mode != LANES_RSV)
                   && (bus.i_nbits != '0)
                   && (int'(bus.i_nbits) <= DATA_W);
    assign w_last   = (r_beat == r_nb - LEN_W'(1));
    assign w_finish = w_tick
                   && (((r_state == ST_HOLD) && !r_upd)
                   || (r_state == ST_UPDATE));

    spi_tick_gen #(.DIV(DIV)) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_accept),
        .i_en    (w_busy),
        .o_tick  (w_tick)
    );

    // mask payload to nbits; left-align for MSB-first
    always_comb begin
        int l;
        int b;
        int sh;
        logic [DATA_W-1:0] data;
        l       = lanes_of(bus.i_lanes_mode);
        b       = beats(int'(bus.i_nbits), l);
        sh      = DATA_W - b * l;
        if (sh < 0) sh = 0;
        w_lanes = 3'(l);
        w_nb    = LEN_W'(b);
        data    = bus.i_data_in
                & ({DATA_W{1'b1}} >> (DATA_W - int'(bus.i_nbits)));
        w_win   = bus.i_msb_first ? (data << sh) : data;
    end

    // current beat slice from the aligned window
    always_comb begin
        w_beat = 4'b0;
        if (r_msb) begin
            unique case (1'b1)
                (r_lanes == 3'd1): w_beat = {3'b0, r_win[DATA_W-1]};
                (r_lanes == 3'd2): w_beat = {2'b0, r_win[DATA_W-1 -: 2]};
                default:           w_beat = r_win[DATA_W-1 -: 4];
            endcase
        end else begin
            unique case (1'b1)
                (r_lanes == 3'd1): w_beat = {3'b0, r_win[0]};
                (r_lanes == 3'd2): w_beat = {2'b0, r_win[1:0]};
                default:           w_beat = r_win[3:0];
            endcase
        end
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SETUP;
            ST_SETUP:  if (w_tick) w_next = ST_SHIFT;
            ST_SHIFT:  if (w_tick && r_phase && w_last) w_next = ST_HOLD;
            ST_HOLD:   if (w_tick) w_next = r_upd ? ST_UPDATE : ST_IDLE;
            ST_UPDATE: if (w_tick) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // pin levels per state
    always_comb begin
        w_cs_n = 1'b1;
        w_sclk = 1'b1;
        w_sdio = 4'b0;
        w_iou  = 1'b0;
        unique case (r_state)
            ST_SETUP:  w_cs_n = 1'b0;
            ST_SHIFT: begin
                w_cs_n = 1'b0;
                w_sclk = r_phase;
                w_sdio = w_beat;
            end
            ST_HOLD: begin
                w_cs_n = 1'b0;
                w_sdio = w_beat;
            end
            ST_UPDATE: w_iou = 1'b1;
            default:   w_cs_n = 1'b1;
        endcase
    end

    // latch request, walk beats, register done
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_win   <= '0;
            r_beat  <= '0;
            r_nb    <= '0;
            r_lanes <= 3'd0;
            r_phase <= 1'b0;
            r_msb   <= 1'b0;
            r_upd   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_win   <= w_win;
                r_beat  <= '0;
                r_nb    <= w_nb;
                r_lanes <= w_lanes;
                r_phase <= 1'b0;
                r_msb   <= bus.i_msb_first;
                r_upd   <= bus.i_io_update_req;
            end else if ((r_state == ST_SHIFT) && w_tick) begin
                if (!r_phase) begin
                    r_phase <= 1'b1;
                end else if (!w_last) begin
                    r_phase <= 1'b0;
                    r_beat  <= r_beat + LEN_W'(1);
                    r_win   <= r_msb ? (r_win << r_lanes)
                                     : (r_win >> r_lanes);
                end
            end
        end
    end

    assign bus.o_busy      = w_busy;
    assign bus.o_done      = r_done;
    assign bus.o_cs_n      = w_cs_n;
    assign bus.o_sclk      = w_sclk;
    assign bus.o_sdio      = w_sdio;
    assign bus.o_io_update = w_iou;
endmodule
